// File: rtl/cordic_multiplier_if.sv
// cordic_multiplier_if: start/busy/done handshake and operand/result bus for the CORDIC multiplier.
interface cordic_multiplier_if #(parameter int W = 22);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] p;
    logic         ovf;
    modport master (output start, a, b, input busy, done, p, ovf);
    modport slave  (input start, a, b, output busy, done, p, ovf);
endinterface

// File: rtl/cordic_multiplier.sv
// cordic_multiplier: iterative linear-rotation CORDIC computing p = a*b on signed Q9.12, one step per clock.
// Define CORDIC_MUL_SAT_EN to saturate p on overflow; otherwise p wraps.
module cordic_multiplier #(
    parameter int W        = 22,
    parameter int FRAC     = 12,
    parameter int NEG_ITER = 9,
    parameter int POS_ITER = 12
) (
    input logic clk,
    input logic rst_n,
    cordic_multiplier_if.slave bus
);
    localparam int NITER = NEG_ITER + POS_ITER + 1;
    localparam int AW = W + NEG_ITER + 2;
    localparam int ZW = W + 2;
    localparam int CW = $clog2(NITER + 1);
    localparam logic [CW-1:0] KN = CW'(NEG_ITER);
    localparam logic [CW-1:0] KL = CW'(NITER - 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state_q, state_d;
    logic [W-1:0] a_q, a_d, p_q, p_d, p_c;
    logic signed [ZW-1:0] z_q, z_d, z_step;
    logic signed [AW-1:0] acc_q, acc_d, a_ext, t;
    logic [CW-1:0] k_q, k_d;
    logic busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, ovf_c, pos;
    // Step k has weight 2^(NEG_ITER-k); k is the step index so no signed exponent is needed.
    always_comb begin
        a_ext  = {{(AW-W){a_q[W-1]}}, a_q};
        t      = (k_q <= KN) ? (a_ext <<< (KN - k_q)) : (a_ext >>> (k_q - KN));
        z_step = {{(ZW-1){1'b0}}, 1'b1} <<< (KL - k_q);
        pos    = ~z_q[ZW-1];
        ovf_c  = acc_q[AW-1:W-1] != {(AW-W+1){acc_q[W-1]}};
`ifdef CORDIC_MUL_SAT_EN
        p_c    = ovf_c ? (acc_q[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : acc_q[W-1:0];
`else
        p_c    = acc_q[W-1:0];
`endif
        state_d = state_q;
        a_d     = a_q;
        z_d     = z_q;
        acc_d   = acc_q;
        k_d     = k_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        p_d     = p_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (bus.start) begin
                a_d     = bus.a;
                z_d     = {{(ZW-W){bus.b[W-1]}}, bus.b};
                acc_d   = '0;
                k_d     = '0;
                busy_d  = 1'b1;
                state_d = CALC;
            end
            CALC: begin
                acc_d   = pos ? acc_q + t : acc_q - t;
                z_d     = pos ? z_q - z_step : z_q + z_step;
                k_d     = k_q + CW'(1);
                state_d = (k_q == KL) ? DONE : CALC;
            end
            DONE: begin
                p_d     = p_c;
                ovf_d   = ovf_c;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            z_q     <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            p_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            z_q     <= z_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            p_q     <= p_d;
            ovf_q   <= ovf_d;
        end
    end
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.p    = p_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_cordic_multiplier.sv
// tb_cordic_multiplier: randomized self-checking bench against an exact-product reference with the CORDIC error bound.
module tb_cordic_multiplier;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    cordic_multiplier_if #(.W(22)) bus ();
    cordic_multiplier dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    // Distance of p from the exact real product, in units of 2^-24; wrap folds modulo the 22-bit result range.
    function automatic longint err_of(logic [21:0] a, logic [21:0] b, logic [21:0] p, bit wrap);
        longint m = 64'sd1 <<< 34;
        longint d = longint'($signed(p)) * 4096 - longint'($signed(a)) * longint'($signed(b));
        if (wrap) begin
            d = ((d % m) + m) % m;
            if (d >= (m >>> 1)) d -= m;
        end
        return d < 0 ? -d : d;
    endfunction

    function automatic longint lim_of(logic [21:0] a);
        longint av = longint'($signed(a));
        if (av < 0) av = -av;
        return (14 + (av >>> 12)) * 4096;
    endfunction

    function automatic logic [21:0] rnd16();
        return 22'($urandom_range(0, 131072)) - 22'd65536;
    endfunction

    task automatic do_op(input logic [21:0] av, input logic [21:0] bv, output logic [21:0] pr,
                         output logic of, output int lat, output logic bsy);
        @(negedge clk);
        bus.start = 1'b1; bus.a = av; bus.b = bv;
        @(posedge clk); #1;
        bsy = bus.busy;
        bus.start = 1'b0; bus.a = 22'($urandom); bus.b = 22'($urandom);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (bus.done) begin lat = c; break; end
        end
        pr = bus.p; of = bus.ovf;
    endtask

    task automatic test_reset();
        total += 4;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
        if (bus.p !== 22'h0) begin bad++; $display("FAIL reset_p got=%h exp=0", bus.p); end
        if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", bus.ovf); end
    endtask

    task automatic test_directed();
        logic [21:0] as [2] = '{22'h002000, 22'h3FE800};
        logic [21:0] bs [2] = '{22'h003000, 22'h002800};
        logic [21:0] pr; logic of, bsy; int lat;
        for (int i = 0; i < 2; i++) begin
            do_op(as[i], bs[i], pr, of, lat, bsy);
            total += 4;
            if (lat !== 23) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=23", i, lat); end
            if (bsy !== 1'b1) begin bad++; $display("FAIL dir%0d_busy got=%0b exp=1", i, bsy); end
            if (err_of(as[i], bs[i], pr, 0) > lim_of(as[i])) begin
                bad++; $display("FAIL dir%0d_p got=%h a=%h b=%h", i, pr, as[i], bs[i]);
            end
            if (of !== 1'b0) begin bad++; $display("FAIL dir%0d_ovf got=%0b exp=0", i, of); end
        end
    endtask

    task automatic test_overflow();
        logic [21:0] as [2] = '{22'h064000, 22'h39C000};
        logic [21:0] pr; logic of, bsy; int lat;
        for (int i = 0; i < 2; i++) begin
            do_op(as[i], 22'h064000, pr, of, lat, bsy);
            total += 2;
            if (of !== 1'b1) begin bad++; $display("FAIL ovf%0d_flag got=%0b exp=1", i, of); end
`ifdef CORDIC_MUL_SAT_EN
            if (pr !== (i == 0 ? 22'h1FFFFF : 22'h200000)) begin
                bad++; $display("FAIL ovf%0d_sat got=%h exp=%h", i, pr, i == 0 ? 22'h1FFFFF : 22'h200000);
            end
`else
            if (err_of(as[i], 22'h064000, pr, 1) > lim_of(as[i])) begin
                bad++; $display("FAIL ovf%0d_wrap got=%h a=%h", i, pr, as[i]);
            end
`endif
        end
    endtask

    task automatic test_random();
        logic [21:0] av, bv, pr; logic of, bsy; int lat;
        for (int i = 0; i < 8; i++) begin
            av = rnd16(); bv = rnd16();
            do_op(av, bv, pr, of, lat, bsy);
            total += 3;
            if (lat !== 23) begin bad++; $display("FAIL rnd%0d_latency got=%0d exp=23", i, lat); end
            if (err_of(av, bv, pr, 0) > lim_of(av)) begin
                bad++; $display("FAIL rnd%0d_p got=%h a=%h b=%h", i, pr, av, bv);
            end
            if (of !== 1'b0) begin bad++; $display("FAIL rnd%0d_ovf got=%0b exp=0", i, of); end
        end
    endtask

    task automatic test_ignore_start();
        logic [21:0] av = 22'h003800, bv = 22'h3FD000;
        logic [21:0] pr = '0;
        int n = 0, lat = -1;
        @(negedge clk);
        bus.start = 1'b1; bus.a = av; bus.b = bv;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.a = 22'h010000; bus.b = 22'h010000;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            bus.start = (c == 4 || c == 9);
            if (bus.done) begin n++; if (lat < 0) begin lat = c; pr = bus.p; end end
        end
        bus.start = 1'b0;
        total += 3;
        if (n !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", n); end
        if (lat !== 23) begin bad++; $display("FAIL ignore_latency got=%0d exp=23", lat); end
        if (err_of(av, bv, pr, 0) > lim_of(av)) begin bad++; $display("FAIL ignore_p got=%h", pr); end
    endtask

    task automatic test_reset_mid();
        logic [21:0] pr; logic of, bsy; int lat, n = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 22'h005000; bus.b = 22'h002000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (11) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total += 4;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%0b exp=0", bus.busy); end
        if (bus.done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%0b exp=0", bus.done); end
        if (bus.p !== 22'h0) begin bad++; $display("FAIL midrst_p got=%h exp=0", bus.p); end
        if (bus.ovf !== 1'b0) begin bad++; $display("FAIL midrst_ovf got=%0b exp=0", bus.ovf); end
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin @(posedge clk); #1; if (bus.done) n++; end
        total += 1;
        if (n !== 0) begin bad++; $display("FAIL midrst_spurious_done got=%0d exp=0", n); end
        do_op(22'h001000, 22'h001000, pr, of, lat, bsy);
        total += 2;
        if (err_of(22'h001000, 22'h001000, pr, 0) > lim_of(22'h001000)) begin
            bad++; $display("FAIL midrst_p_after got=%h exp=001000", pr);
        end
        if (lat !== 23) begin bad++; $display("FAIL midrst_latency got=%0d exp=23", lat); end
    endtask

    task automatic test_back_to_back();
        logic [21:0] oa [0:127];
        logic [21:0] ob [0:127];
        int last = -1, nd = 0, k;
        @(posedge clk); #1;
        for (int e = 0; e < 110; e++) begin
            oa[e+1] = rnd16(); ob[e+1] = rnd16();
            bus.start = 1'b1; bus.a = oa[e+1]; bus.b = ob[e+1];
            @(posedge clk); #1;
            if (bus.done) begin
                k = e + 1 - 23;
                total += 1;
                if (err_of(oa[k], ob[k], bus.p, 0) > lim_of(oa[k])) begin
                    bad++; $display("FAIL b2b_p got=%h a=%h b=%h", bus.p, oa[k], ob[k]);
                end
                if (last >= 0) begin
                    total += 1;
                    if (e + 1 - last !== 24) begin bad++; $display("FAIL b2b_period got=%0d exp=24", e + 1 - last); end
                end
                last = e + 1; nd++;
            end
        end
        bus.start = 1'b0;
        repeat (30) @(posedge clk);
        total += 1;
        if (nd !== 4) begin bad++; $display("FAIL b2b_done_count got=%0d exp=4", nd); end
    endtask

    initial begin
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        test_directed();
        test_overflow();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
